// File: rtl/cpc_rom_pkg.sv
// cpc_rom_pkg: shared FSM state, page constants and decode helpers for the ROM loader.
package cpc_rom_pkg;
   typedef enum logic [1:0] {IDLE, ARM, WRITE} state_t;
   localparam logic [8:0] PAGE_DEFAULT = 9'h1EE;
   localparam logic [8:0] PAGE_MF2 = 9'h1FF;
   localparam logic [8:0] BOOT_PAGES [4] = '{9'h000, 9'h100, 9'h107, 9'h1FF};
   function automatic logic [8:0] boot_page(input logic [1:0] i);
      return BOOT_PAGES[i];
   endfunction
   // {valid, value} for one ASCII upper-case hex digit
   function automatic logic [4:0] hex_nib(input logic [7:0] c);
      return (c >= "0" && c <= "9") ? {1'b1, c[3:0]} :
             (c >= "A" && c <= "F") ? {1'b1, c[3:0] + 4'd9} : 5'd0;
   endfunction
endpackage

// File: rtl/ext_page_decode.sv
// ext_page_decode: turns the two-character file extension into a ROM page and combo flag.
module ext_page_decode
   import cpc_rom_pkg::*;
(
   input  logic [15:0] ext,
   output logic [8:0]  page,
   output logic        combo
);
   logic [4:0] hi, lo;
   logic       z_hi;
   assign hi = hex_nib(ext[15:8]);
   assign lo = hex_nib(ext[7:0]);
   assign z_hi = ext[15:8] == "Z";
   always_comb begin
      page = PAGE_DEFAULT;
      combo = 1'b0;
      if (hi[4]) page[7:4] = hi[3:0];
      if (lo[4]) page[3:0] = lo[3:0];
      if (z_hi && (ext[7:0] == "Z" || ext[7:0] == "0")) begin
         page = '0;
         combo = ext[7:0] == "0";
      end
   end
endmodule

// File: rtl/cpc_rom_loader.sv
// cpc_rom_loader: paces hps_io download bytes into SDRAM boot writes aligned to ce_ref,
// and records which upper-ROM pages have been loaded.
module cpc_rom_loader
   import cpc_rom_pkg::*;
#(
   parameter int MAP_PAGES = 256
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ce_ref,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [7:0]  ioctl_index,
   input  logic [31:0] ioctl_file_ext,
   output logic        ioctl_wait,
   output logic        boot_wr,
   output logic [22:0] boot_a,
   output logic [1:0]  boot_bank,
   output logic [7:0]  boot_dout,
   input  logic [7:0]  map_addr,
   output logic        rom_mapped
);
   state_t                 state;
   logic                   dl_q, combo, dual, dec_combo;
   logic [8:0]             page, dec_page, tgt;
   logic [MAP_PAGES-1:0]   rom_map;
   logic                   idx0, map_ok, dual_req;
   logic [1:0]             bank;
   logic                   unused_ext;

   ext_page_decode u_dec (
      .ext   (ioctl_file_ext[15:0]),
      .page  (dec_page),
      .combo (dec_combo)
   );

   assign unused_ext = ^ioctl_file_ext[31:16];
   assign idx0 = ioctl_index == 8'd0;
   // boot ROM set: only file pages 0-7 exist, the upper four mirror the lower into bank 1
   assign map_ok = !idx0 || ioctl_addr[24:14] < 11'd8;
   assign tgt = idx0 ? boot_page(ioctl_addr[15:14]) : {page[8], page[7:0] + ioctl_addr[21:14]};
   assign bank = {1'b0, idx0 ? ioctl_addr[16] : &ioctl_index[7:6]};
   assign dual_req = (ioctl_index[7:6] == 2'd1 || |ioctl_index[5:0]) && !bank[0];

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state <= IDLE;
         ioctl_wait <= 1'b0;
         boot_wr <= 1'b0;
         boot_a <= '0;
         boot_bank <= '0;
         boot_dout <= '0;
         rom_mapped <= 1'b0;
         rom_map <= '0;
         page <= PAGE_DEFAULT;
         combo <= 1'b0;
         dual <= 1'b0;
         dl_q <= 1'b0;
      end else begin
         dl_q <= ioctl_download;
         rom_mapped <= rom_map[map_addr];
         if (ioctl_download && !dl_q && !idx0) begin
            page <= dec_page;
            combo <= dec_combo;
         end
         case (state)
            IDLE: if (ioctl_download && ioctl_wr && map_ok) begin
               boot_a <= {tgt, ioctl_addr[13:0]};
               boot_dout <= ioctl_dout;
               boot_bank <= bank;
               dual <= dual_req;
               ioctl_wait <= 1'b1;
               state <= ARM;
            end
            ARM: if (ce_ref) begin
               boot_wr <= 1'b1;
               state <= WRITE;
            end
            WRITE: if (ce_ref) begin
               boot_wr <= 1'b0;
               if (dual) begin
                  dual <= 1'b0;
                  boot_bank <= 2'd1;
                  state <= ARM;
               end else begin
                  ioctl_wait <= 1'b0;
                  state <= IDLE;
                  if (boot_a[22]) rom_map[boot_a[21:14]] <= 1'b1;
                  // multiface combo image: the 16K after the first page belongs to the MF2 slot
                  if (combo && boot_a[13:0] == 14'h3FFF) begin
                     combo <= 1'b0;
                     page <= PAGE_MF2;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
